// File: rtl/scale_pkg.sv
// Shared definitions for the ROM->RAM pixel-replication path.
// Holds the sequencer state encoding, the default source image geometry and
// the frame-RAM depth derivation. The same values are used by rom_to_ram and
// by the VGA reader so that all three agree on frame size.
package scale_pkg;

    // Source image geometry defaults and replication factor for mode=1
    localparam int LARGURA_DEF = 160;
    localparam int ALTURA_DEF  = 120;
    localparam int FATOR_DEF   = 2;

    // Frame RAM port widths
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    // Sequencer state encoding
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_KICK  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    // Words in one upscaled frame; the RAM is always sized for the FATORx
    // image so that a 1x image is written over a fully cleared buffer.
    function automatic int ram_depth(input int largura, input int altura,
                                     input int fator);
        return largura * fator * altura * fator;
    endfunction

endpackage

// File: rtl/scale_seq_ctrl_switch_filter.sv
// switch_filter: synchronizes the raw mode switch and debounces it.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   i_switch  in   raw switch, asynchronous to clk
//   o_mode    out  accepted (debounced) mode
//   o_change  out  one-cycle pulse, high in the cycle the new mode is taken
module switch_filter #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_switch,
    output logic o_mode,
    output logic o_change
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             w_differ;

    // Two-flop synchronizer chain
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= (gi == 0) ? i_switch : r_sync[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign w_differ = (r_sync[1] != r_mode);
    // r_cnt counts differing cycles already seen; this cycle is the last one
    // needed, so the new mode is taken at the coming edge.
    assign o_change = w_differ && (r_cnt == CNT_LAST);
    assign o_mode   = r_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (!w_differ) begin
            // any bounce back to the accepted value restarts the count
            r_cnt <= '0;
        end else if (o_change) begin
            r_mode <= r_sync[1];
            r_cnt  <= '0;
        end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scale_seq_ctrl.sv
// scale_seq_ctrl: sequencer for the ROM->RAM pixel-replication engine.
// Debounces the mode switch, clears the frame RAM, restarts the engine in the
// selected mode and flags frame_valid once a complete frame is in RAM.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   switch                       raw mode switch (0=1x, 1=FATORx)
//   start                        one-cycle rebuild request
//   eng_done                     engine finished (level)
//   eng_wraddr/eng_data/eng_wren engine RAM write request
//   eng_rst                      engine held idle while high
//   eng_switch                   mode latched for the engine at KICK
//   ram_wraddr/ram_data/ram_wren the single RAM write port
//   busy                         high in CLEAR/KICK/RUN
//   frame_valid                  high only in VALID
module scale_seq_ctrl
    import scale_pkg::*;
#(
    parameter int LARGURA       = LARGURA_DEF,
    parameter int ALTURA        = ALTURA_DEF,
    parameter int FATOR         = FATOR_DEF,
    parameter int RAM_DEPTH     = ram_depth(LARGURA, ALTURA, FATOR),
    parameter int STABLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              switch,
    input  logic              start,
    input  logic              eng_done,
    input  logic [ADDR_W-1:0] eng_wraddr,
    input  logic [DATA_W-1:0] eng_data,
    input  logic              eng_wren,
    output logic              eng_rst,
    output logic              eng_switch,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              frame_valid
);

    // RAM_DEPTH must fit the 19-bit clear address (<= 2**19 words)
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RAM_DEPTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_eng_rst;
    logic              r_eng_switch;
    logic              r_pending;
    logic              w_mode;
    logic              w_change;
    logic              w_pend_now;
    logic              w_clr_last;

    switch_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .i_switch(switch),
        .o_mode  (w_mode),
        .o_change(w_change)
    );

    // A request arriving this very cycle counts as pending, so a start that
    // coincides with eng_done still aborts instead of publishing the frame.
    assign w_pend_now = r_pending | start | w_change;
    assign w_clr_last = (r_clr_addr == CLR_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_next = ST_KICK;
            ST_KICK:  w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_pend_now)    w_state_next = ST_CLEAR;
                else if (eng_done) w_state_next = ST_VALID;
            end
            ST_VALID: if (w_pend_now) w_state_next = ST_CLEAR;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_clr_addr   <= '0;
            r_eng_rst    <= 1'b1;
            r_eng_switch <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            // engine is released only while running
            r_eng_rst <= (w_state_next != ST_RUN);
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
            end
            if (r_state == ST_KICK) begin
                r_eng_switch <= w_mode;
            end
            // a new request wins over the KICK clear so it is never lost
            if (start || w_change) begin
                r_pending <= 1'b1;
            end else if (r_state == ST_KICK) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Write-port mux: clear writes, engine pass-through, or idle
    always_comb begin
        ram_wraddr = '0;
        ram_data   = '0;
        ram_wren   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                ram_wraddr = r_clr_addr;
                ram_wren   = ~reset;  // no write while reset is held
            end
            ST_RUN: begin
                ram_wraddr = eng_wraddr;
                ram_data   = eng_data;
                ram_wren   = eng_wren;
            end
            default: ;
        endcase
    end

    assign eng_rst     = r_eng_rst;
    assign eng_switch  = r_eng_switch;
    assign busy        = (r_state != ST_VALID);
    assign frame_valid = (r_state == ST_VALID);

endmodule
